// File: rtl/mod_ctr_pkg.sv
// mod_ctr_pkg
// Shared definitions for the modulus-N up/down counter:
//   DIR_UP / DIR_DN : encodings of the up_dn input
//   mod_chk_t       : result of sanitize_mod (legal value plus error bit)
//   sanitize_mod    : maps a requested modulus onto the legal range 1..max_n
package mod_ctr_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  typedef struct packed {
    logic        bad;
    logic [31:0] value;
  } mod_chk_t;

  // A modulus of 0, or one larger than the counter can represent, is replaced
  // by max_n and reported as bad. A modulus of 1 is legal (count pinned at 0).
  function automatic mod_chk_t sanitize_mod(input logic [31:0] val,
                                            input logic [31:0] max_n);
    mod_chk_t r;
    if (val == 32'd0 || val > max_n) begin
      r.bad   = 1'b1;
      r.value = max_n;
    end else begin
      r.bad   = 1'b0;
      r.value = val;
    end
    return r;
  endfunction

endpackage

// File: rtl/mod_n_cfg.sv
// mod_n_cfg
// Modulus configuration for mod_n_updown_ctr. Holds the pending modulus and
// its flag, the modulus in effect and the sticky error flag.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   mod_wr     : stage mod_val (sanitised) as the pending modulus
//   mod_val    : requested modulus
//   apply      : counter wraps or loads this edge; pending modulus takes effect
//   clamp_err  : counter clamped a load value this edge; sets err
//   mod_act    : modulus currently in effect
//   mod_eff    : modulus that will be in effect after this edge if apply is high
//   err        : sticky configuration error, cleared only by rst
module mod_n_cfg
  import mod_ctr_pkg::*;
#(
  parameter int MAX_N = 16,
  parameter int MW    = $clog2(MAX_N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mod_wr,
  input  logic [MW-1:0] mod_val,
  input  logic          apply,
  input  logic          clamp_err,
  output logic [MW-1:0] mod_act,
  output logic [MW-1:0] mod_eff,
  output logic          err
);

  localparam logic [MW-1:0] MAX_MOD = MW'(MAX_N);

  logic [MW-1:0] pend;
  logic          pend_flag;
  logic [MW-1:0] mod_san;
  mod_chk_t      chk;

  assign chk     = sanitize_mod(32'(mod_val), 32'(MAX_N));
  assign mod_san = MW'(chk.value);

  // The counter needs the modulus that governs the edge it is computing, so a
  // pending value is forwarded ahead of being registered into mod_act.
  assign mod_eff = pend_flag ? pend : mod_act;

  // A strobe coincident with apply overwrites the pending register only after
  // the old pending value has been moved into mod_act, so the new one stays
  // pending for the next wrap or load.
  always_ff @(posedge clk) begin
    if (rst) begin
      mod_act   <= MAX_MOD;
      pend      <= MAX_MOD;
      pend_flag <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (apply && pend_flag) begin
        mod_act <= pend;
      end
      if (mod_wr) begin
        pend      <= mod_san;
        pend_flag <= 1'b1;
      end else if (apply) begin
        pend_flag <= 1'b0;
      end
      if ((mod_wr && chk.bad) || clamp_err) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mod_n_updown_ctr.sv
// mod_n_updown_ctr
// Up/down counter with a run-time programmable modulus.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   en        : count enable
//   up_dn     : direction, DIR_UP counts up, DIR_DN counts down
//   load      : load load_val (clamped to mod-1) this edge; beats en
//   load_val  : value to load
//   mod_wr    : stage mod_val as the pending modulus
//   mod_val   : requested modulus
//   count     : registered count
//   tc        : one-cycle pulse alongside the count value produced by a wrap
//   mod_act   : modulus currently in effect
//   err       : sticky configuration error
module mod_n_updown_ctr
  import mod_ctr_pkg::*;
#(
  parameter int MAX_N = 16,
  parameter int WIDTH = $clog2(MAX_N),
  parameter int MW    = $clog2(MAX_N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mod_wr,
  input  logic [MW-1:0]    mod_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic [MW-1:0]    mod_act,
  output logic             err
);

  logic [MW-1:0]    mod_eff;
  logic [MW-1:0]    act_m1;
  logic [MW-1:0]    eff_m1;
  logic [MW-1:0]    count_ext;
  logic [MW-1:0]    load_ext;
  logic             at_top;
  logic             at_bot;
  logic             wrap;
  logic             clamp;
  logic             apply;
  logic [WIDTH-1:0] count_nxt;

  mod_n_cfg #(
    .MAX_N (MAX_N),
    .MW    (MW)
  ) u_cfg (
    .clk       (clk),
    .rst       (rst),
    .mod_wr    (mod_wr),
    .mod_val   (mod_val),
    .apply     (apply),
    .clamp_err (clamp),
    .mod_act   (mod_act),
    .mod_eff   (mod_eff),
    .err       (err)
  );

  // Wrap detection uses the modulus in effect now; the value written after
  // the wrap (and any load clamp) uses the modulus that takes effect on it.
  assign count_ext = MW'(count);
  assign load_ext  = MW'(load_val);
  assign act_m1    = mod_act - 1'b1;
  assign eff_m1    = mod_eff - 1'b1;
  assign at_top    = (count_ext == act_m1);
  assign at_bot    = (count == '0);
  assign wrap      = en && !load && ((up_dn == DIR_UP) ? at_top : at_bot);
  assign clamp     = load && (load_ext >= mod_eff);
  assign apply     = wrap || load;

  // Next count: load outranks en; with neither the count holds.
  always_comb begin
    count_nxt = count;
    if (load) begin
      count_nxt = clamp ? WIDTH'(eff_m1) : load_val;
    end else if (en) begin
      if (up_dn == DIR_UP) begin
        count_nxt = at_top ? '0 : count + 1'b1;
      end else if (up_dn == DIR_DN) begin
        count_nxt = at_bot ? WIDTH'(eff_m1) : count - 1'b1;
      end
    end
  end

  // tc is registered from the wrap condition so it lines up with the
  // wrapped count value; loads never raise it.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      tc    <= 1'b0;
    end else begin
      count <= count_nxt;
      tc    <= wrap;
    end
  end

endmodule

// File: tb/tb_mod_n_updown_ctr.sv
module tb_mod_n_updown_ctr;

  localparam int MAX_N = 10;
  localparam int WIDTH = $clog2(MAX_N);
  localparam int MW    = $clog2(MAX_N + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             mod_wr;
  logic [MW-1:0]    mod_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic [MW-1:0]    mod_act;
  logic             err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mod_n_updown_ctr #(.MAX_N(MAX_N)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .mod_wr   (mod_wr),
    .mod_val  (mod_val),
    .count    (count),
    .tc       (tc),
    .mod_act  (mod_act),
    .err      (err)
  );

  // Advance one rising edge and settle past it before sampling.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; en = 1'b0; load = 1'b0; mod_wr = 1'b0;
    up_dn = 1'b1; load_val = '0; mod_val = '0;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    checks++; if (count !== 4'd0) begin errors++; $display("[TB] FAIL reset_count got %0d want 0", count); end
    checks++; if (tc !== 1'b0) begin errors++; $display("[TB] FAIL reset_tc got %0b want 0", tc); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %0b want 0", err); end
    checks++; if (mod_act !== 4'd10) begin errors++; $display("[TB] FAIL reset_mod_act got %0d want 10", mod_act); end
  endtask

  task automatic test_count_up;
    int exp_c [11] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};
    int exp_t [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    do_reset;
    en = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tick;
      checks++; if (count !== WIDTH'(exp_c[i])) begin errors++; $display("[TB] FAIL up_count[%0d] got %0d want %0d", i, count, exp_c[i]); end
      checks++; if (tc !== 1'(exp_t[i])) begin errors++; $display("[TB] FAIL up_tc[%0d] got %0b want %0d", i, tc, exp_t[i]); end
    end
    en = 1'b0;
  endtask

  task automatic test_count_down;
    int exp_c [3] = '{9, 8, 7};
    int exp_t [3] = '{1, 0, 0};
    do_reset;
    en = 1'b1; up_dn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++; if (count !== WIDTH'(exp_c[i])) begin errors++; $display("[TB] FAIL dn_count[%0d] got %0d want %0d", i, count, exp_c[i]); end
      checks++; if (tc !== 1'(exp_t[i])) begin errors++; $display("[TB] FAIL dn_tc[%0d] got %0b want %0d", i, tc, exp_t[i]); end
    end
    en = 1'b0;
  endtask

  task automatic test_mod_switch;
    int exp_c [12] = '{4, 5, 6, 7, 8, 9, 0, 1, 2, 3, 4, 0};
    int exp_m [12] = '{10, 10, 10, 10, 10, 10, 5, 5, 5, 5, 5, 5};
    int exp_t [12] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    do_reset;
    en = 1'b1; up_dn = 1'b1;
    tick; tick; tick;
    checks++; if (count !== 4'd3) begin errors++; $display("[TB] FAIL sw_start got %0d want 3", count); end
    mod_val = 4'd5;
    for (int i = 0; i < 12; i++) begin
      mod_wr = (i == 0);
      tick;
      checks++; if (count !== WIDTH'(exp_c[i])) begin errors++; $display("[TB] FAIL sw_count[%0d] got %0d want %0d", i, count, exp_c[i]); end
      checks++; if (mod_act !== MW'(exp_m[i])) begin errors++; $display("[TB] FAIL sw_mod_act[%0d] got %0d want %0d", i, mod_act, exp_m[i]); end
      checks++; if (tc !== 1'(exp_t[i])) begin errors++; $display("[TB] FAIL sw_tc[%0d] got %0b want %0d", i, tc, exp_t[i]); end
    end
    mod_wr = 1'b0; en = 1'b0;
  endtask

  task automatic test_load;
    do_reset;
    load = 1'b1; load_val = 4'd12; en = 1'b1; up_dn = 1'b1;
    tick;
    checks++; if (count !== 4'd9) begin errors++; $display("[TB] FAIL ld_clamp_count got %0d want 9", count); end
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL ld_clamp_err got %0b want 1", err); end
    checks++; if (tc !== 1'b0) begin errors++; $display("[TB] FAIL ld_clamp_tc got %0b want 0", tc); end
    load = 1'b0;
    tick;
    checks++; if (count !== 4'd0 || tc !== 1'b1) begin errors++; $display("[TB] FAIL ld_wrap got count %0d tc %0b want 0 1", count, tc); end
    load = 1'b1; load_val = 4'd9;
    tick;
    load_val = 4'd2;
    tick;
    checks++; if (count !== 4'd2 || tc !== 1'b0) begin errors++; $display("[TB] FAIL ld_at_top got count %0d tc %0b want 2 0", count, tc); end
    load = 1'b0; en = 1'b0;
    tick;
    checks++; if (count !== 4'd2 || tc !== 1'b0) begin errors++; $display("[TB] FAIL ld_hold got count %0d tc %0b want 2 0", count, tc); end
    do_reset;
    mod_wr = 1'b1; mod_val = 4'd5;
    tick;
    checks++; if (mod_act !== 4'd10) begin errors++; $display("[TB] FAIL ld_pend_early got %0d want 10", mod_act); end
    mod_wr = 1'b0; load = 1'b1; load_val = 4'd7;
    tick;
    checks++; if (count !== 4'd4) begin errors++; $display("[TB] FAIL ld_pend_count got %0d want 4", count); end
    checks++; if (mod_act !== 4'd5) begin errors++; $display("[TB] FAIL ld_pend_mod got %0d want 5", mod_act); end
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL ld_pend_err got %0b want 1", err); end
    load = 1'b0;
  endtask

  task automatic test_bad_mod;
    do_reset;
    mod_wr = 1'b1; mod_val = 4'd3;
    tick;
    mod_wr = 1'b0; load = 1'b1; load_val = 4'd0;
    tick;
    load = 1'b0;
    checks++; if (mod_act !== 4'd3 || err !== 1'b0) begin errors++; $display("[TB] FAIL bad_setup got mod %0d err %0b want 3 0", mod_act, err); end
    mod_wr = 1'b1; mod_val = 4'd0;
    tick;
    mod_wr = 1'b0;
    checks++; if (mod_act !== 4'd3) begin errors++; $display("[TB] FAIL bad_pending got %0d want 3", mod_act); end
    en = 1'b1; up_dn = 1'b1;
    tick; tick; tick;
    checks++; if (count !== 4'd0 || tc !== 1'b1) begin errors++; $display("[TB] FAIL bad_wrap got count %0d tc %0b want 0 1", count, tc); end
    checks++; if (mod_act !== 4'd10) begin errors++; $display("[TB] FAIL bad_mod_act got %0d want 10", mod_act); end
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL bad_err got %0b want 1", err); end
    tick; tick; tick;
    checks++; if (count !== 4'd3) begin errors++; $display("[TB] FAIL bad_newmod_count got %0d want 3", count); end
    en = 1'b0;
  endtask

  task automatic test_mod_one;
    int dirs [5] = '{1, 1, 1, 0, 0};
    do_reset;
    mod_wr = 1'b1; mod_val = 4'd1;
    tick;
    mod_wr = 1'b0; load = 1'b1; load_val = 4'd0;
    tick;
    load = 1'b0;
    checks++; if (mod_act !== 4'd1 || err !== 1'b0) begin errors++; $display("[TB] FAIL one_setup got mod %0d err %0b want 1 0", mod_act, err); end
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      up_dn = 1'(dirs[i]);
      tick;
      checks++; if (count !== 4'd0 || tc !== 1'b1) begin errors++; $display("[TB] FAIL one_step[%0d] got count %0d tc %0b want 0 1", i, count, tc); end
    end
    en = 1'b0;
    tick;
    checks++; if (count !== 4'd0 || tc !== 1'b0) begin errors++; $display("[TB] FAIL one_idle got count %0d tc %0b want 0 0", count, tc); end
  endtask

  task automatic test_coincident;
    do_reset;
    mod_wr = 1'b1; mod_val = 4'd4;
    tick;
    mod_val = 4'd6; load = 1'b1; load_val = 4'd1;
    tick;
    checks++; if (mod_act !== 4'd4 || count !== 4'd1) begin errors++; $display("[TB] FAIL co_load1 got mod %0d count %0d want 4 1", mod_act, count); end
    mod_wr = 1'b0; load_val = 4'd5;
    tick;
    load = 1'b0;
    checks++; if (mod_act !== 4'd6 || count !== 4'd5) begin errors++; $display("[TB] FAIL co_load2 got mod %0d count %0d want 6 5", mod_act, count); end
    en = 1'b1; up_dn = 1'b1; mod_wr = 1'b1; mod_val = 4'd3;
    tick;
    mod_wr = 1'b0;
    checks++; if (count !== 4'd0 || tc !== 1'b1 || mod_act !== 4'd6) begin errors++; $display("[TB] FAIL co_wrap1 got count %0d tc %0b mod %0d want 0 1 6", count, tc, mod_act); end
    for (int i = 0; i < 6; i++) tick;
    checks++; if (count !== 4'd0 || tc !== 1'b1 || mod_act !== 4'd3) begin errors++; $display("[TB] FAIL co_wrap2 got count %0d tc %0b mod %0d want 0 1 3", count, tc, mod_act); end
    en = 1'b0;
  endtask

  task automatic test_direction;
    int dirs  [4] = '{1, 0, 0, 1};
    int exp_c [4] = '{6, 5, 4, 5};
    do_reset;
    load = 1'b1; load_val = 4'd5;
    tick;
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      up_dn = 1'(dirs[i]);
      tick;
      checks++; if (count !== WIDTH'(exp_c[i])) begin errors++; $display("[TB] FAIL dir_count[%0d] got %0d want %0d", i, count, exp_c[i]); end
    end
    en = 1'b0;
    tick;
    checks++; if (count !== 4'd5) begin errors++; $display("[TB] FAIL dir_hold got %0d want 5", count); end
  endtask

  task automatic test_reset_override;
    do_reset;
    load = 1'b1; load_val = 4'd15;
    tick;
    load_val = 4'd7;
    tick;
    checks++; if (count !== 4'd7 || err !== 1'b1) begin errors++; $display("[TB] FAIL ovr_setup got count %0d err %0b want 7 1", count, err); end
    rst = 1'b1; load_val = 4'd3; en = 1'b1; up_dn = 1'b1; mod_wr = 1'b1; mod_val = 4'd2;
    tick;
    checks++; if (count !== 4'd0) begin errors++; $display("[TB] FAIL ovr_count got %0d want 0", count); end
    checks++; if (tc !== 1'b0) begin errors++; $display("[TB] FAIL ovr_tc got %0b want 0", tc); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL ovr_err got %0b want 0", err); end
    checks++; if (mod_act !== 4'd10) begin errors++; $display("[TB] FAIL ovr_mod_act got %0d want 10", mod_act); end
    rst = 1'b0; mod_wr = 1'b0; en = 1'b0; load = 1'b1; load_val = 4'd9;
    tick;
    load = 1'b0;
    checks++; if (count !== 4'd9 || mod_act !== 4'd10) begin errors++; $display("[TB] FAIL ovr_no_pend got count %0d mod %0d want 9 10", count, mod_act); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0;
    load_val = '0; mod_wr = 1'b0; mod_val = '0;
    test_reset;
    test_count_up;
    test_count_down;
    test_mod_switch;
    test_load;
    test_bad_mod;
    test_mod_one;
    test_coincident;
    test_direction;
    test_reset_override;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout reached at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

endmodule
